// File: rtl/amo_if.sv
// amo_if: bundles the pipeline-side amo_req/amo_ack handshake, the D-side
// memory port and the snoop inputs seen by amo_unit.
// The slave modport is the amo_unit side; master is the pipeline/memory side.
interface amo_if #(
  parameter int XLEN = 64
);
  logic            amo_req;
  logic            amo_ack;
  logic [4:0]      amo_funct5;
  logic            amo_d;
  logic [XLEN-1:0] amo_addr;
  logic [XLEN-1:0] amo_rs2;
  logic [XLEN-1:0] amo_rd;
  logic            amo_err;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rd;
  logic            mem_wr;
  logic            mem_d;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;
  logic            snoop_inv;
  logic [XLEN-1:0] snoop_addr;

  modport slave (
    input  amo_req, amo_funct5, amo_d, amo_addr, amo_rs2,
    input  mem_rdata, mem_ack, snoop_inv, snoop_addr,
    output amo_ack, amo_rd, amo_err,
    output mem_addr, mem_rd, mem_wr, mem_d, mem_wdata
  );

  modport master (
    output amo_req, amo_funct5, amo_d, amo_addr, amo_rs2,
    output mem_rdata, mem_ack, snoop_inv, snoop_addr,
    input  amo_ack, amo_rd, amo_err,
    input  mem_addr, mem_rd, mem_wr, mem_d, mem_wdata
  );
endinterface

// File: rtl/amo_unit.sv
// amo_unit: executes one RV64A atomic as a locked read-modify-write on the
// D-side memory port, holding the pipeline until a one-cycle amo_ack.
// Sequence: IDLE -> LOAD -> EXEC -> STORE -> DONE -> IDLE.
// Optional LR/SC with a single reservation granule: define RV6_AMO_LRSC_EN.
// Without it LR/SC report amo_err and the snoop inputs are ignored.
module amo_unit #(
  parameter int XLEN     = 64,
  parameter int RES_GRAN = 3
) (
  input logic   clk,
  input logic   rst_n,
  amo_if.slave  bus
);

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_STORE, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic            dw_q, dw_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] old_q, old_d;
  logic            amo_ack_q, amo_ack_d;
  logic            amo_err_q, amo_err_d;
  logic [XLEN-1:0] amo_rd_q, amo_rd_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            req_misaligned;
`ifdef RV6_AMO_LRSC_EN
  logic                     res_vld_q, res_vld_d;
  logic [XLEN-1:RES_GRAN]   res_addr_q, res_addr_d;
`else
  localparam int unused_gran = RES_GRAN;
  logic unused_snoop;
  assign unused_snoop = ^{bus.snoop_inv, bus.snoop_addr, F_LR, F_SC};
`endif

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

  // .W store data carries only its low word; upper bits are driven to zero.
  function automatic logic [XLEN-1:0] narrow(input logic [XLEN-1:0] x, input logic dw);
    return dw ? x : {{(XLEN-32){1'b0}}, x[31:0]};
  endfunction

  function automatic logic op_known(input logic [4:0] f);
    case (f)
      F_ADD, F_SWAP, F_XOR, F_OR, F_AND, F_MIN, F_MAX, F_MINU, F_MAXU: return 1'b1;
`ifdef RV6_AMO_LRSC_EN
      F_LR, F_SC: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Read-modify-write result at operand width. For .W both operands are
  // re-extended from bit 31 (signed) or zero-extended (unsigned) so the
  // full-width compare only sees the low word.
  function automatic logic [XLEN-1:0] amo_alu(input logic [4:0] f, input logic dw,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [XLEN-1:0]        ua, ub, r;
    logic                   lt_s, lt_u;
    sa   = dw ? a : sext32(a);
    sb   = dw ? b : sext32(b);
    ua   = narrow(a, dw);
    ub   = narrow(b, dw);
    lt_s = sa < sb;
    lt_u = ua < ub;
    case (f)
      F_ADD:   r = a + b;
      F_SWAP:  r = b;
      F_XOR:   r = a ^ b;
      F_OR:    r = a | b;
      F_AND:   r = a & b;
      F_MIN:   r = lt_s ? a : b;
      F_MAX:   r = lt_s ? b : a;
      F_MINU:  r = lt_u ? a : b;
      F_MAXU:  r = lt_u ? b : a;
      default: r = b;
    endcase
    return narrow(r, dw);
  endfunction

  assign req_misaligned = bus.amo_d ? (|bus.amo_addr[2:0]) : (|bus.amo_addr[1:0]);

  // Next-state and next-output computation for the whole RMW sequence
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dw_d        = dw_q;
    rs2_d       = rs2_q;
    old_d       = old_q;
    amo_ack_d   = 1'b0;
    amo_err_d   = 1'b0;
    amo_rd_d    = amo_rd_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef RV6_AMO_LRSC_EN
    res_vld_d   = res_vld_q;
    res_addr_d  = res_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.amo_req) begin
          op_d       = bus.amo_funct5;
          dw_d       = bus.amo_d;
          rs2_d      = bus.amo_rs2;
          mem_addr_d = bus.amo_addr;
          if (req_misaligned || !op_known(bus.amo_funct5)) begin
            amo_ack_d = 1'b1;
            amo_err_d = 1'b1;
            amo_rd_d  = '0;
            state_d   = S_DONE;
          end
`ifdef RV6_AMO_LRSC_EN
          else if (bus.amo_funct5 == F_SC) begin
            res_vld_d = 1'b0;
            if (res_vld_q && (bus.amo_addr[XLEN-1:RES_GRAN] == res_addr_q)) begin
              mem_wr_d    = 1'b1;
              mem_wdata_d = narrow(bus.amo_rs2, bus.amo_d);
              old_d       = '0;
              state_d     = S_STORE;
            end else begin
              amo_ack_d = 1'b1;
              amo_rd_d  = {{(XLEN-1){1'b0}}, 1'b1};
              state_d   = S_DONE;
            end
          end
`endif
          else begin
            mem_rd_d = 1'b1;
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (bus.mem_ack) begin
          mem_rd_d = 1'b0;
          old_d    = dw_q ? bus.mem_rdata : sext32(bus.mem_rdata);
`ifdef RV6_AMO_LRSC_EN
          if (op_q == F_LR) begin
            amo_ack_d  = 1'b1;
            amo_rd_d   = old_d;
            res_vld_d  = 1'b1;
            res_addr_d = mem_addr_q[XLEN-1:RES_GRAN];
            state_d    = S_DONE;
          end else
`endif
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        mem_wdata_d = amo_alu(op_q, dw_q, old_q, rs2_q);
        mem_wr_d    = 1'b1;
        state_d     = S_STORE;
      end
      S_STORE: begin
        if (bus.mem_ack) begin
          mem_wr_d  = 1'b0;
          amo_ack_d = 1'b1;
          amo_rd_d  = old_q;
          state_d   = S_DONE;
`ifdef RV6_AMO_LRSC_EN
          if (mem_addr_q[XLEN-1:RES_GRAN] == res_addr_q) res_vld_d = 1'b0;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef RV6_AMO_LRSC_EN
    // A snoop in the same cycle an LR sets the granule still wins.
    if (bus.snoop_inv && (bus.snoop_addr[XLEN-1:RES_GRAN] == res_addr_d)) res_vld_d = 1'b0;
`endif
  end

  // Control state and visible outputs; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= F_ADD;
      dw_q        <= 1'b0;
      amo_ack_q   <= 1'b0;
      amo_err_q   <= 1'b0;
      amo_rd_q    <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef RV6_AMO_LRSC_EN
      res_vld_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dw_q        <= dw_d;
      amo_ack_q   <= amo_ack_d;
      amo_err_q   <= amo_err_d;
      amo_rd_q    <= amo_rd_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef RV6_AMO_LRSC_EN
      res_vld_q   <= res_vld_d;
`endif
    end
  end

  // Operand registers; only read after an accepted request has loaded them
  always_ff @(posedge clk) begin
    rs2_q      <= rs2_d;
    old_q      <= old_d;
`ifdef RV6_AMO_LRSC_EN
    res_addr_q <= res_addr_d;
`endif
  end

  assign bus.amo_ack   = amo_ack_q;
  assign bus.amo_err   = amo_err_q;
  assign bus.amo_rd    = amo_rd_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_d     = dw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
